key_debouncer_bank: RTL and testbench

Multi-channel switch debouncer with per-channel hysteresis, press/release event pulses and auto-repeat. It replaces single-channel debouncers in the keypad front end of the countdown timer. Raw, unsynchronised-to-slow-tick button levels come in; clean levels and one-CLK-cycle key events go out to the control FSM.

---
 rtl/key_debouncer_bank.sv | 155 +++++++++++++++
 tb/tb_key_debouncer_bank.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer_bank.sv
// Multi-channel key debouncer with hysteresis filter, press/release pulses and auto-repeat.
// Optional feature macro: KEY_REPEAT_ACCEL_EN enables repeat-rate acceleration.
module key_debouncer_bank #(
    parameter int CHANNELS           = 4,
    parameter int FILTER_LEN         = 4,
    parameter int REPEAT_DELAY       = 100,
    parameter int REPEAT_PERIOD      = 25,
    parameter int ACCEL_AFTER        = 8,
    parameter int REPEAT_FAST_PERIOD = 5
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                CE,
    input  logic [CHANNELS-1:0] REP_EN,
    input  logic [CHANNELS-1:0] S_IN,
    output logic [CHANNELS-1:0] KEY_EN,
    output logic [CHANNELS-1:0] KEY_UP,
    output logic [CHANNELS-1:0] KEY_REL,
    output logic                ANY_KEY
);

    // Every timing parameter bounds the counter, so its width is the same in both builds.
    localparam int MAX_DP  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_DPF = (MAX_DP > REPEAT_FAST_PERIOD) ? MAX_DP : REPEAT_FAST_PERIOD;
    localparam int CNT_MAX = (MAX_DPF > ACCEL_AFTER) ? MAX_DPF : ACCEL_AFTER;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef KEY_REPEAT_ACCEL_EN
    localparam int               ACC_W   = $clog2(ACCEL_AFTER + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(ACCEL_AFTER);
    localparam logic [CNT_W-1:0] FAST_LD = CNT_W'(REPEAT_FAST_PERIOD);
`endif

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } key_state_t;

    key_state_t            state_q [CHANNELS];
    key_state_t            state_d [CHANNELS];
    // The oldest sample of the window is never needed again, so only FILTER_LEN-1 are stored.
    logic [FILTER_LEN-2:0] hist_q  [CHANNELS];
    logic [FILTER_LEN-2:0] hist_d  [CHANNELS];
    logic [FILTER_LEN-1:0] win     [CHANNELS];
    logic [CNT_W-1:0]      cnt_q   [CHANNELS];
    logic [CNT_W-1:0]      cnt_d   [CHANNELS];
    logic [CHANNELS-1:0]   up_d;
    logic [CHANNELS-1:0]   rel_d;
    logic [CHANNELS-1:0]   en_d;

`ifdef KEY_REPEAT_ACCEL_EN
    logic [ACC_W-1:0]      acc_q   [CHANNELS];
    logic [ACC_W-1:0]      acc_d   [CHANNELS];
`endif

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // NOTE: every comb output gets a default before any branch, so no latch can be inferred.
            state_d[i] = state_q[i];
            hist_d[i]  = hist_q[i];
            win[i]     = {hist_q[i], S_IN[i]};
            cnt_d[i]   = cnt_q[i];
            up_d[i]    = 1'b0;
            rel_d[i]   = 1'b0;
`ifdef KEY_REPEAT_ACCEL_EN
            acc_d[i]   = acc_q[i];
`endif
            if (CE) begin
                hist_d[i] = win[i][FILTER_LEN-2:0];
                case (state_q[i])
                    RELEASED: begin
                        if (&win[i]) begin
                            state_d[i] = PRESSED;
                            up_d[i]    = 1'b1;
                            cnt_d[i]   = DELAY_LD;
`ifdef KEY_REPEAT_ACCEL_EN
                            acc_d[i]   = '0;
`endif
                        end
                    end
                    PRESSED: begin
                        if (~|win[i]) begin
                            // Release takes priority over a repeat due on the same tick.
                            state_d[i] = RELEASED;
                            rel_d[i]   = 1'b1;
                            cnt_d[i]   = DELAY_LD;
`ifdef KEY_REPEAT_ACCEL_EN
                            acc_d[i]   = '0;
`endif
                        end else if (!REP_EN[i]) begin
                            cnt_d[i] = DELAY_LD;
`ifdef KEY_REPEAT_ACCEL_EN
                            acc_d[i] = '0;
`endif
                        end else if (cnt_q[i] == CNT_ONE) begin
                            up_d[i] = 1'b1;
`ifdef KEY_REPEAT_ACCEL_EN
                            cnt_d[i] = (acc_q[i] < ACC_MAX) ? PERIOD_LD : FAST_LD;
                            if (acc_q[i] < ACC_MAX) begin
                                acc_d[i] = acc_q[i] + ACC_W'(1);
                            end
`else
                            cnt_d[i] = PERIOD_LD;
`endif
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    default: state_d[i] = RELEASED;
                endcase
            end
            en_d[i] = (state_d[i] == PRESSED);
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            KEY_EN[i] = (state_q[i] == PRESSED);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= RELEASED;
                hist_q[i]  <= '0;
                cnt_q[i]   <= DELAY_LD;
`ifdef KEY_REPEAT_ACCEL_EN
                acc_q[i]   <= '0;
`endif
            end
            KEY_UP  <= '0;
            KEY_REL <= '0;
            ANY_KEY <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                hist_q[i]  <= hist_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef KEY_REPEAT_ACCEL_EN
                acc_q[i]   <= acc_d[i];
`endif
            end
            KEY_UP  <= up_d;
            KEY_REL <= rel_d;
            ANY_KEY <= |en_d;
        end
    end

endmodule

// File: tb/tb_key_debouncer_bank.sv
// Scoreboard bench for key_debouncer_bank: two instances (repeat period 3 and 6) share stimulus.
// Expected outputs come from a run-length behavioural model pushed to a queue every cycle.
module tb_key_debouncer_bank;
    localparam int FL    = 4;
    localparam int DELAY = 10;
    localparam int AA    = 2;
    localparam int FAST  = 2;
`ifdef KEY_REPEAT_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       CLR;
    logic       CE;
    logic [3:0] REP_EN;
    logic [3:0] S_IN;
    logic [3:0] a_en, a_up, a_rel;
    logic       a_any;
    logic [3:0] b_en, b_up, b_rel;
    logic       b_any;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] up;
        logic [3:0] rel;
        logic       any;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    int m_val  [2][4];
    int m_len  [2][4];
    int m_prs  [2][4];
    int m_el   [2][4];
    int m_tgt  [2][4];
    int m_nacc [2][4];

    always #5 CLK = ~CLK;

    key_debouncer_bank #(
        .CHANNELS(4), .FILTER_LEN(FL), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(3),
        .ACCEL_AFTER(AA), .REPEAT_FAST_PERIOD(FAST)
    ) dut_a (
        .CLK(CLK), .CLR(CLR), .CE(CE), .REP_EN(REP_EN), .S_IN(S_IN),
        .KEY_EN(a_en), .KEY_UP(a_up), .KEY_REL(a_rel), .ANY_KEY(a_any)
    );

    key_debouncer_bank #(
        .CHANNELS(4), .FILTER_LEN(FL), .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(6),
        .ACCEL_AFTER(AA), .REPEAT_FAST_PERIOD(FAST)
    ) dut_b (
        .CLK(CLK), .CLR(CLR), .CE(CE), .REP_EN(REP_EN), .S_IN(S_IN),
        .KEY_EN(b_en), .KEY_UP(b_up), .KEY_REL(b_rel), .ANY_KEY(b_any)
    );

    // Model: tracks the current run of equal samples instead of a shift register, and counts
    // ticks up since the last press/repeat/restart toward a target interval.
    function automatic obs_t model_step(input int k, input int period, input logic ce,
                                        input logic clr, input logic [3:0] s, input logic [3:0] rep);
        obs_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            if (clr) begin
                m_val[k][c] = 0; m_len[k][c] = FL; m_prs[k][c] = 0;
                m_el[k][c] = 0; m_tgt[k][c] = DELAY; m_nacc[k][c] = 0;
            end else if (ce) begin
                if (int'(s[c]) == m_val[k][c]) begin
                    if (m_len[k][c] < FL) m_len[k][c]++;
                end else begin
                    m_val[k][c] = int'(s[c]);
                    m_len[k][c] = 1;
                end
                if (m_prs[k][c] == 0) begin
                    if (m_val[k][c] == 1 && m_len[k][c] >= FL) begin
                        m_prs[k][c] = 1; o.up[c] = 1'b1;
                        m_el[k][c] = 0; m_tgt[k][c] = DELAY; m_nacc[k][c] = 0;
                    end
                end else if (m_val[k][c] == 0 && m_len[k][c] >= FL) begin
                    m_prs[k][c] = 0; o.rel[c] = 1'b1;
                    m_el[k][c] = 0; m_tgt[k][c] = DELAY; m_nacc[k][c] = 0;
                end else if (!rep[c]) begin
                    m_el[k][c] = 0; m_tgt[k][c] = DELAY; m_nacc[k][c] = 0;
                end else begin
                    m_el[k][c]++;
                    if (m_el[k][c] == m_tgt[k][c]) begin
                        o.up[c] = 1'b1;
                        m_el[k][c] = 0;
                        m_tgt[k][c] = (ACCEL && m_nacc[k][c] >= AA) ? FAST : period;
                        if (m_nacc[k][c] < AA) m_nacc[k][c]++;
                    end
                end
            end
            o.en[c] = (m_prs[k][c] != 0);
        end
        o.any = |o.en;
        return o;
    endfunction

    function automatic exp_t obs_now();
        return exp_t'({a_en, a_up, a_rel, a_any, b_en, b_up, b_rel, b_any});
    endfunction

    task automatic step(input logic ce_v, input logic clr_v, input logic [3:0] s_v,
                        input logic [3:0] rep_v);
        exp_t e;
        CE = ce_v; CLR = clr_v; S_IN = s_v; REP_EN = rep_v;
        e.a = model_step(0, 3, ce_v, clr_v, s_v, rep_v);
        e.b = model_step(1, 6, ce_v, clr_v, s_v, rep_v);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int t = 0; t < 2; t++) begin
            step(1'b1, 1'b1, 4'hF, 4'hF);
            e = exp_q.pop_front();
            total++;
            if (obs_now() !== e) begin
                bad++; $display("FAIL reset_sb t=%0d got=%h want=%h", t, obs_now(), e);
            end
            total++;
            if ({a_en, a_up, a_rel, a_any} !== 13'd0) begin
                bad++; $display("FAIL reset_outputs got=%b want=0", {a_en, a_up, a_rel, a_any});
            end
        end
    endtask

    task automatic test_filter();
        exp_t e;
        logic [7:0] seq;
        seq = 8'b1111_0111;
        for (int t = 0; t < 9; t++) begin
            step(1'b1, 1'b0, {3'b000, (t < 8) ? seq[t] : 1'b1}, 4'h0);
            e = exp_q.pop_front();
            total++;
            if (obs_now() !== e) begin
                bad++; $display("FAIL filter_sb t=%0d got=%h want=%h", t, obs_now(), e);
            end
            if (t == 2) begin
                total++;
                if (a_en !== 4'b0000 || a_up !== 4'b0000) begin
                    bad++; $display("FAIL filter_short got en=%b up=%b want 0000", a_en, a_up);
                end
            end else if (t == 7) begin
                total++;
                if (a_en !== 4'b0001 || a_up !== 4'b0001) begin
                    bad++; $display("FAIL filter_press got en=%b up=%b want 0001", a_en, a_up);
                end
            end else if (t == 8) begin
                total++;
                if (a_en !== 4'b0001 || a_up !== 4'b0000) begin
                    bad++; $display("FAIL filter_pulse got en=%b up=%b want en=0001 up=0000", a_en, a_up);
                end
            end
        end
    endtask

    task automatic test_hysteresis();
        exp_t e;
        for (int t = 0; t < 8; t++) begin
            step(1'b1, 1'b0, {3'b000, t[0]}, 4'h0);
            e = exp_q.pop_front();
            total++;
            if (obs_now() !== e || a_en !== 4'b0001 || a_rel !== 4'b0000) begin
                bad++; $display("FAIL hyst_hold t=%0d got=%h want=%h", t, obs_now(), e);
            end
        end
        for (int t = 0; t < 5; t++) begin
            step(1'b1, 1'b0, 4'h0, 4'h0);
            e = exp_q.pop_front();
            total++;
            if (obs_now() !== e) begin
                bad++; $display("FAIL hyst_rel_sb t=%0d got=%h want=%h", t, obs_now(), e);
            end
            if (t >= 3) begin
                total++;
                if (a_rel !== ((t == 3) ? 4'b0001 : 4'b0000) || a_en !== 4'b0000) begin
                    bad++; $display("FAIL hyst_release t=%0d got rel=%b en=%b", t, a_rel, a_en);
                end
            end
        end
    endtask

    task automatic release_all();
        exp_t e;
        for (int t = 0; t < 4; t++) begin
            step(1'b1, 1'b0, 4'h0, 4'h0);
            e = exp_q.pop_front();
            total++;
            if (obs_now() !== e) begin
                bad++; $display("FAIL release_sb t=%0d got=%h want=%h", t, obs_now(), e);
            end
        end
    endtask

    task automatic test_repeat();
        exp_t e;
        int   o;
        logic want;
        for (int t = 0; t < 21; t++) begin
            o = t - 3;
            step(1'b1, 1'b0, 4'b0010, 4'b0010);
            e = exp_q.pop_front();
            want = (o == 0 || o == 10 || o == 13 || o == 16);
            total++;
            if (obs_now() !== e || a_up[1] !== want) begin
                bad++; $display("FAIL repeat_held o=%0d got up1=%b want %b (%h vs %h)", o, a_up[1], want, obs_now(), e);
            end
        end
        release_all();
        for (int t = 0; t < 35; t++) begin
            o = t - 3;
            step(1'b1, 1'b0, 4'b0010, (o >= 15 && o <= 20) ? 4'b0000 : 4'b0010);
            e = exp_q.pop_front();
            want = (o == 0 || o == 10 || o == 13 || o == 30);
            total++;
            if (obs_now() !== e || a_up[1] !== want) begin
                bad++; $display("FAIL repeat_reen o=%0d got up1=%b want %b (%h vs %h)", o, a_up[1], want, obs_now(), e);
            end
        end
        release_all();
    endtask

    task automatic test_simultaneous();
        exp_t e;
        for (int t = 0; t < 5; t++) begin
            step(1'b1, 1'b0, 4'b0101, 4'h0);
            e = exp_q.pop_front();
            total++;
            if (obs_now() !== e) begin
                bad++; $display("FAIL simul_sb t=%0d got=%h want=%h", t, obs_now(), e);
            end
            if (t >= 3) begin
                total++;
                if (a_up !== ((t == 3) ? 4'b0101 : 4'b0000) || a_any !== 1'b1) begin
                    bad++; $display("FAIL simul_press t=%0d got up=%b any=%b", t, a_up, a_any);
                end
            end
        end
        release_all();
    endtask

    task automatic test_clr();
        exp_t e;
        for (int t = 0; t < 15; t++) begin
            step(1'b1, 1'b0, 4'b0010, 4'b0010);
            e = exp_q.pop_front();
            total++;
            if (obs_now() !== e) begin
                bad++; $display("FAIL clr_pre_sb t=%0d got=%h want=%h", t, obs_now(), e);
            end
        end
        step(1'b1, 1'b1, 4'b0010, 4'b0010);
        e = exp_q.pop_front();
        total++;
        if (obs_now() !== exp_t'(0) || e !== exp_t'(0)) begin
            bad++; $display("FAIL clr_zero got=%h want=0", obs_now());
        end
        for (int t = 0; t < 4; t++) begin
            step(1'b1, 1'b0, 4'b0010, 4'b0010);
            e = exp_q.pop_front();
            total++;
            if (obs_now() !== e || a_en !== ((t == 3) ? 4'b0010 : 4'b0000)) begin
                bad++; $display("FAIL clr_redetect t=%0d got=%h want=%h", t, obs_now(), e);
            end
        end
        release_all();
    endtask

    task automatic test_ce_gate();
        exp_t e;
        logic ce_v;
        for (int t = 0; t < 8; t++) begin
            ce_v = (t % 2 == 0) && (t < 7);
            step(ce_v, 1'b0, ce_v ? 4'b0100 : 4'b0000, 4'h0);
            e = exp_q.pop_front();
            total++;
            if (obs_now() !== e) begin
                bad++; $display("FAIL ce_sb t=%0d got=%h want=%h", t, obs_now(), e);
            end
            if (t >= 5) begin
                total++;
                if (a_en !== ((t == 5) ? 4'b0000 : 4'b0100) || a_up !== ((t == 6) ? 4'b0100 : 4'b0000)) begin
                    bad++; $display("FAIL ce_gate t=%0d got en=%b up=%b", t, a_en, a_up);
                end
            end
        end
        release_all();
    endtask

    task automatic test_accel();
        exp_t e;
        int   o;
        logic want;
        for (int t = 0; t < 40; t++) begin
            o = t - 3;
            step(1'b1, 1'b0, 4'b1000, 4'b1000);
            e = exp_q.pop_front();
            if (ACCEL) want = (o == 0 || o == 10 || o == 16 || (o >= 22 && (o - 22) % 2 == 0));
            else       want = (o == 0 || (o >= 10 && (o - 10) % 6 == 0));
            total++;
            if (obs_now() !== e || b_up[3] !== want) begin
                bad++; $display("FAIL accel_spacing o=%0d got up3=%b want %b (%h vs %h)", o, b_up[3], want, obs_now(), e);
            end
        end
        release_all();
    endtask

    task automatic test_random();
        exp_t e;
        logic [3:0] s, rep;
        s = 4'h0; rep = 4'h0;
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < 4; c++) if ($urandom_range(0, 3) == 0) s[c] = ~s[c];
            if ($urandom_range(0, 19) == 0) rep = 4'($urandom_range(0, 15));
            step($urandom_range(0, 4) != 0, $urandom_range(0, 59) == 0, s, rep);
            e = exp_q.pop_front();
            total++;
            if (obs_now() !== e) begin
                bad++; $display("FAIL random_sb t=%0d got=%h want=%h", t, obs_now(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_filter();
        test_hysteresis();
        test_repeat();
        test_simultaneous();
        test_clr();
        test_ce_gate();
        test_accel();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
